// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit path.
// The FIFO side is fixed at 8-bit bytes; the frame may carry fewer data bits.
package uart_pkg;

    localparam int   DATA_W_DEF     = 8;
    localparam int   DIV_W_DEF      = 16;
    localparam logic IDLE_LEVEL_DEF = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // Parity over the low 'width' bits of a byte; odd=1 makes the total count of ones odd.
    function automatic logic frame_parity(input logic [7:0] data,
                                          input int unsigned width,
                                          input logic odd);
        logic p;
        p = odd;
        for (int i = 0; i < 8; i++) begin
            if (i < int'(width)) p = p ^ data[i];
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Loadable down-counter that marks the last clk cycle of each bit period.
// A period of load_val+1 cycles follows every load; bit_end is held off while disabled.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    output logic             bit_end
);

    logic [DIV_W-1:0] baud_cnt;

    assign bit_end = en && (baud_cnt == '0);

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // always_ff in this path reads the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= '0;
        end else if (load) begin
            baud_cnt <= load_val;
        end else if (en && (baud_cnt != '0)) begin
            baud_cnt <= baud_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter fed by a first-word-fall-through FIFO through rd_vld/rd_en.
// The final stop-bit cycle doubles as the accept slot for the next byte, so frames run back to back.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int   DATA_W     = DATA_W_DEF,
    parameter int   DIV_W      = DIV_W_DEF,
    parameter logic IDLE_LEVEL = IDLE_LEVEL_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] baud_div,
    input  logic             parity_en,
    input  logic             parity_odd,
    input  logic             stop2,
    input  logic [7:0]       data_in,
    input  logic             data_in_valid,
    output logic             data_in_ready,
    output logic             txd,
    output logic             busy,
    output logic             tx_done
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_W - 1);

    uart_state_t       state;
    uart_state_t       state_next;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_next;
    logic [2:0]        bit_cnt;
    logic              stop_cnt;
    logic [DIV_W-1:0]  baud_div_l;
    logic              parity_en_l;
    logic              stop2_l;
    logic              parity_l;
    logic              txd_next;
    logic              bit_end;
    logic              last_stop;
    logic              frame_end;
    logic              accept;
    logic              baud_load;

    assign last_stop     = (stop_cnt == stop2_l);
    assign frame_end     = (state == ST_STOP) && last_stop && bit_end;
    // Gated by rst_n so the FIFO never sees rd_en while the block is held in reset.
    assign data_in_ready = rst_n && ((state == ST_IDLE) || frame_end);
    assign accept        = data_in_valid && data_in_ready;
    assign tx_done       = frame_end;

    // A new byte takes precedence over the idle return in the final stop-bit cycle.
    assign baud_load = accept || (bit_end && (state_next != ST_IDLE));

    uart_baud_tick #(
        .DIV_W(DIV_W)
    ) u_baud_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (state != ST_IDLE),
        .load    (baud_load),
        .load_val(accept ? baud_div : baud_div_l),
        .bit_end (bit_end)
    );

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   state_next = ST_IDLE;
            ST_START:  if (bit_end) state_next = ST_DATA;
            ST_DATA:   if (bit_end && (bit_cnt == LAST_BIT))
                           state_next = parity_en_l ? ST_PARITY : ST_STOP;
            ST_PARITY: if (bit_end) state_next = ST_STOP;
            ST_STOP:   if (frame_end) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
        if (accept) state_next = ST_START;
    end

    always_comb begin
        shift_next = shift_reg;
        if (accept) begin
            shift_next = data_in[DATA_W-1:0];
        end else if ((state == ST_DATA) && bit_end) begin
            shift_next = {1'b0, shift_reg[DATA_W-1:1]};
        end
    end

    // txd is registered, so it is driven from the state being entered, not the current one.
    always_comb begin
        txd_next = IDLE_LEVEL;
        case (state_next)
            ST_START:  txd_next = 1'b0;
            ST_DATA:   txd_next = shift_next[0];
            ST_PARITY: txd_next = parity_l;
            ST_STOP:   txd_next = 1'b1;
            default:   txd_next = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            stop_cnt    <= 1'b0;
            baud_div_l  <= '0;
            parity_en_l <= 1'b0;
            stop2_l     <= 1'b0;
            parity_l    <= 1'b0;
            txd         <= IDLE_LEVEL;
            busy        <= 1'b0;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            txd       <= txd_next;
            busy      <= (state_next != ST_IDLE);
            if (accept) begin
                baud_div_l  <= baud_div;
                parity_en_l <= parity_en;
                stop2_l     <= stop2;
                parity_l    <= frame_parity(data_in, DATA_W, parity_odd);
                bit_cnt     <= '0;
                stop_cnt    <= 1'b0;
            end else begin
                if ((state == ST_DATA) && bit_end) begin
                    bit_cnt <= (bit_cnt == LAST_BIT) ? 3'd0 : bit_cnt + 3'd1;
                end
                if ((state == ST_STOP) && bit_end) begin
                    stop_cnt <= last_stop ? 1'b0 : 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench: a queue stands in for the prefetch FIFO; txd, busy, tx_done and pops are checked per cycle.
module tb_uart_tx_serializer;

    logic        clk;
    logic        rst_n;
    logic [15:0] baud_div;
    logic        parity_en;
    logic        parity_odd;
    logic        stop2;
    logic [7:0]  data_in;
    logic        data_in_valid;
    logic        data_in_ready;
    logic        txd;
    logic        busy;
    logic        tx_done;

    int vectors;
    int miscompares;
    int pop_cnt;

    logic [7:0] fifo_q[$];

    logic s_txd;
    logic s_busy;
    logic s_done;
    logic s_pop;

    uart_tx_serializer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .baud_div     (baud_div),
        .parity_en    (parity_en),
        .parity_odd   (parity_odd),
        .stop2        (stop2),
        .data_in      (data_in),
        .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready),
        .txd          (txd),
        .busy         (busy),
        .tx_done      (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_fifo();
        data_in_valid = (fifo_q.size() > 0);
        data_in       = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        drive_fifo();
    endtask

    // Sample one cycle mid-period, then pop the FIFO model if a handshake occurred at the edge.
    task automatic step();
        @(negedge clk);
        s_txd  = txd;
        s_busy = busy;
        s_done = tx_done;
        s_pop  = data_in_valid && data_in_ready;
        @(posedge clk);
        #1;
        if (s_pop && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            pop_cnt++;
        end
        drive_fifo();
    endtask

    // Accepts the byte at the FIFO head (must equal b) and checks the whole frame cycle by cycle.
    task automatic frame_test(input string tag, input logic [7:0] b, input logic [15:0] div,
                              input logic pen, input logic podd, input logic exp_par,
                              input logic st2, input int flip_at, input logic [15:0] flip_div);
        logic exp_bits[12];
        int   nbits;
        int   total;
        int   per;
        baud_div   = div;
        parity_en  = pen;
        parity_odd = podd;
        stop2      = st2;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[1 + i] = b[i];
        for (int i = 9; i < 12; i++) exp_bits[i] = 1'b1;
        if (pen) exp_bits[9] = exp_par;
        nbits = 10 + int'(pen) + int'(st2);
        per   = int'(div) + 1;
        total = nbits * per;
        step();
        check({tag, "_accept_pop"}, 32'(s_pop), 32'd1);
        for (int c = 1; c <= total; c++) begin
            if (c == flip_at) baud_div = flip_div;
            step();
            check({tag, "_txd"}, 32'(s_txd), 32'(exp_bits[(c - 1) / per]));
            check({tag, "_busy"}, 32'(s_busy), 32'd1);
            check({tag, "_tx_done"}, 32'(s_done), 32'(c == total));
            check({tag, "_no_pop"}, 32'(s_pop), 32'(0));
        end
        step();
        check({tag, "_busy_after"}, 32'(s_busy), 32'd0);
        check({tag, "_txd_after"}, 32'(s_txd), 32'd1);
    endtask

    initial begin
        logic exp_seq[66];
        logic [7:0] b2b[3];
        int pops_before;

        vectors       = 0;
        miscompares   = 0;
        pop_cnt       = 0;
        rst_n         = 1'b0;
        baud_div      = 16'd3;
        parity_en     = 1'b0;
        parity_odd    = 1'b0;
        stop2         = 1'b0;
        data_in       = 8'h00;
        data_in_valid = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tx_done", 32'(tx_done), 32'd0);
        check("rst_ready", 32'(data_in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // 0xA5, 4-cycle bits, no parity, one stop: tx_done at N+40, busy low at N+41
        push(8'hA5);
        frame_test("a5", 8'hA5, 16'd3, 1'b0, 1'b0, 1'b0, 1'b0, 0, 16'd0);

        // Parity cases, 11 bit periods per frame
        push(8'h03);
        frame_test("p03_even", 8'h03, 16'd2, 1'b1, 1'b0, 1'b0, 1'b0, 0, 16'd0);
        push(8'h07);
        frame_test("p07_odd", 8'h07, 16'd2, 1'b1, 1'b1, 1'b0, 1'b0, 0, 16'd0);
        push(8'h07);
        frame_test("p07_even", 8'h07, 16'd2, 1'b1, 1'b0, 1'b1, 1'b0, 0, 16'd0);

        // baud_div=0: one clk per bit; 0x5A has four ones, so odd parity gives 1
        push(8'h5A);
        frame_test("div0", 8'h5A, 16'd0, 1'b1, 1'b1, 1'b1, 1'b1, 0, 16'd0);

        // Back-to-back: 3 frames of 11 bits x 2 cycles with no gap
        b2b[0] = 8'h55;
        b2b[1] = 8'hAA;
        b2b[2] = 8'h0F;
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 22; k++) begin
                int bit_idx;
                bit_idx = k / 2;
                if (bit_idx == 0)      exp_seq[f * 22 + k] = 1'b0;
                else if (bit_idx <= 8) exp_seq[f * 22 + k] = b2b[f][bit_idx - 1];
                else                   exp_seq[f * 22 + k] = 1'b1;
            end
        end
        baud_div   = 16'd1;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        stop2      = 1'b1;
        pops_before = pop_cnt;
        push(8'h55);
        push(8'hAA);
        push(8'h0F);
        for (int rel = 0; rel <= 67; rel++) begin
            step();
            if (rel <= 66) begin
                check("b2b_pop", 32'(s_pop), 32'(rel == 0 || rel == 22 || rel == 44));
            end
            if (rel >= 1 && rel <= 66) begin
                check("b2b_txd", 32'(s_txd), 32'(exp_seq[rel - 1]));
                check("b2b_busy", 32'(s_busy), 32'd1);
                check("b2b_tx_done", 32'(s_done), 32'(rel % 22 == 0));
            end
            if (rel == 67) begin
                check("b2b_busy_end", 32'(s_busy), 32'd0);
                check("b2b_txd_end", 32'(s_txd), 32'd1);
            end
        end
        check("b2b_pop_count", 32'(pop_cnt - pops_before), 32'd3);

        // Empty FIFO for 100 cycles, then zero-wait accept
        for (int c = 0; c < 100; c++) begin
            step();
            check("empty_state", {29'd0, s_txd, s_busy, s_pop}, 32'b100);
        end
        push(8'h3C);
        frame_test("after_idle", 8'h3C, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 16'd0);

        // Reset during data bit 4 of 0xC3 (bit value 0)
        push(8'hC3);
        baud_div  = 16'd3;
        parity_en = 1'b0;
        stop2     = 1'b0;
        step();
        check("rstmid_pop", 32'(s_pop), 32'd1);
        push(8'h81);
        repeat (21) step();
        check("rstmid_txd_before", 32'(txd), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_txd_async", 32'(txd), 32'd1);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_ready", 32'(data_in_ready), 32'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            check("rstmid_no_pop", 32'(s_pop), 32'd0);
        end
        rst_n = 1'b1;
        frame_test("after_rst", 8'h81, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0, 0, 16'd0);

        // Config change mid-frame: baud_div 3 -> 7 during DATA; next frame uses 8-cycle bits
        push(8'hE1);
        frame_test("cfg_cur", 8'hE1, 16'd3, 1'b0, 1'b0, 1'b0, 1'b0, 12, 16'd7);
        push(8'h1E);
        frame_test("cfg_next", 8'h1E, 16'd7, 1'b0, 1'b0, 1'b0, 1'b0, 0, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
